huff_granule_writer: RTL and testbench

- Sits directly downstream of the per-table Huffman pair decoders (HT_xx) in the MP3 parser.
- Takes signed (x, y) big_values pairs, buffers them in a small FIFO and writes them as single samples into the granule sample RAM at consecutive addresses.
- After the last pair, zero-fills the remaining addresses up to N_SAMPLES-1, then signals done.
- Provides backpressure (pair_ready) so the bit feeder can stall the decoder's axiiv stream.

---
 rtl/mp3_pkg.sv | 26 ++
 rtl/pair_fifo.sv | 69 ++++++
 rtl/huff_granule_writer.sv | 154 +++++++++++++++
 tb/tb_huff_granule_writer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mp3_pkg
// Brief   : Shared constants and types for the MP3 granule sample path.
// Revision: 1.0 - initial release
// ============================================================================
package mp3_pkg;

    localparam int N_SAMPLES      = 576;
    localparam int MAX_BIG_VALUES = 288;
    localparam int PAIR_SAMPLE_W  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        ZERO_FILL = 2'd2,
        DONE      = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [PAIR_SAMPLE_W-1:0] x;
        logic signed [PAIR_SAMPLE_W-1:0] y;
    } pair_t;

endpackage
`default_nettype wire

// File: rtl/pair_fifo.sv
`default_nettype none
// ============================================================================
// Module  : pair_fifo
// Brief   : Power-of-two depth FIFO with same-cycle push/pop and sync clear.
// Revision: 1.0 - initial release
// ============================================================================
module pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push on a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/huff_granule_writer.sv
`default_nettype none
// ============================================================================
// Module  : huff_granule_writer
// Brief   : Buffers decoded (x,y) pairs and writes one granule of samples,
//           zero-filling past big_values, then pulses done.
// Revision: 1.0 - initial release
// ============================================================================
module huff_granule_writer
    import mp3_pkg::*;
#(
    parameter int N_SAMPLES  = 576,
    parameter int FIFO_DEPTH = 4,
    parameter int SAMPLE_W   = 16,
    parameter int ADDR_W     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [8:0]                 big_values,
    input  logic                       pair_valid,
    input  logic signed [SAMPLE_W-1:0] x_val,
    input  logic signed [SAMPLE_W-1:0] y_val,
    output logic                       pair_ready,
    output logic                       sample_we,
    output logic [ADDR_W-1:0]          sample_addr,
    output logic signed [SAMPLE_W-1:0] sample_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err_extra
);

    localparam logic [8:0]        HALF_PAIRS = 9'(N_SAMPLES / 2);
    localparam logic [ADDR_W:0]   END_IDX    = (ADDR_W+1)'(N_SAMPLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_SAMPLES - 1);

    state_t                  state;
    logic [8:0]              bv;
    logic [8:0]              acc_cnt;
    logic [ADDR_W-1:0]       wr_idx;
    logic                    phase;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    fifo_clr;
    logic [2*SAMPLE_W-1:0]   fifo_dout;
    logic [8:0]              bv_in;
    logic [ADDR_W:0]         next_pair_idx;
    logic [ADDR_W:0]         bv_end;

    assign bv_in         = (big_values > HALF_PAIRS) ? HALF_PAIRS : big_values;
    assign pair_ready    = (state == COLLECT) && !fifo_full && (acc_cnt < bv);
    assign push          = pair_valid && pair_ready;
    assign pop           = (state == COLLECT) && phase && !fifo_empty;
    assign fifo_clr      = (state == IDLE) && start;
    assign next_pair_idx = {1'b0, wr_idx} + (ADDR_W+1)'(2);
    assign bv_end        = (ADDR_W+1)'({bv, 1'b0});

    pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (push),
        .din   ({x_val, y_val}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bv          <= '0;
            acc_cnt     <= '0;
            wr_idx      <= '0;
            phase       <= 1'b0;
            sample_we   <= 1'b0;
            sample_addr <= '0;
            sample_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_extra   <= 1'b0;
        end else begin
            sample_we <= 1'b0;
            done      <= 1'b0;
            if (push) begin
                acc_cnt <= acc_cnt + 9'd1;
            end

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        bv        <= bv_in;
                        acc_cnt   <= '0;
                        wr_idx    <= '0;
                        phase     <= 1'b0;
                        err_extra <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (bv_in == 9'd0) ? ZERO_FILL : COLLECT;
                    end
                end

                COLLECT: begin
                    if (pair_valid && !pair_ready && (acc_cnt == bv)) begin
                        err_extra <= 1'b1;
                    end
                    // Each pair takes two cycles: x first, then y with the pop.
                    if (!fifo_empty) begin
                        sample_we <= 1'b1;
                        if (!phase) begin
                            sample_addr <= wr_idx;
                            sample_data <= fifo_dout[2*SAMPLE_W-1:SAMPLE_W];
                            phase       <= 1'b1;
                        end else begin
                            sample_addr <= wr_idx + ADDR_W'(1);
                            sample_data <= fifo_dout[SAMPLE_W-1:0];
                            phase       <= 1'b0;
                            wr_idx      <= next_pair_idx[ADDR_W-1:0];
                            if (next_pair_idx == bv_end) begin
                                state <= (next_pair_idx == END_IDX) ? DONE : ZERO_FILL;
                            end
                        end
                    end
                end

                ZERO_FILL: begin
                    sample_we   <= 1'b1;
                    sample_addr <= wr_idx;
                    sample_data <= '0;
                    if (wr_idx == LAST_ADDR) begin
                        state <= DONE;
                    end else begin
                        wr_idx <= wr_idx + ADDR_W'(1);
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_huff_granule_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_huff_granule_writer
// Brief   : Directed self-checking bench for huff_granule_writer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_huff_granule_writer;
    import mp3_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [8:0]         big_values = '0;
    logic               pair_valid = 1'b0;
    logic signed [15:0] x_val = '0;
    logic signed [15:0] y_val = '0;
    logic               pair_ready;
    logic               sample_we;
    logic [9:0]         sample_addr;
    logic signed [15:0] sample_data;
    logic               busy;
    logic               done;
    logic               err_extra;

    int checks = 0;
    int errors = 0;

    logic [9:0]  log_addr [$];
    logic [15:0] log_data [$];
    logic [15:0] exp_data [N_SAMPLES];
    pair_t       pairs [$];
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
    int acc = 0, ywr = 0, max_occ = 0, tb_bv = 0;
    bit ready_seen = 0, stall_seen = 0;

    always #5 clk = ~clk;

    huff_granule_writer #(
        .N_SAMPLES  (576),
        .FIFO_DEPTH (4),
        .SAMPLE_W   (16),
        .ADDR_W     (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .big_values  (big_values),
        .pair_valid  (pair_valid),
        .x_val       (x_val),
        .y_val       (y_val),
        .pair_ready  (pair_ready),
        .sample_we   (sample_we),
        .sample_addr (sample_addr),
        .sample_data (sample_data),
        .busy        (busy),
        .done        (done),
        .err_extra   (err_extra)
    );

    // Write log plus FIFO occupancy derived from handshakes and y writes.
    always @(negedge clk) begin
        int occ;
        cyc = cyc + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (sample_we) begin
            log_addr.push_back(sample_addr);
            log_data.push_back(sample_data);
            last_wr_cyc = cyc;
            if (sample_addr[0] && (int'(sample_addr) < 2 * tb_bv)) ywr = ywr + 1;
        end
        occ = acc - ywr;
        if (occ > max_occ) max_occ = occ;
        if (pair_ready) ready_seen = 1;
        if (pair_valid && !pair_ready && busy) stall_seen = 1;
        if (pair_valid && pair_ready) acc = acc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log(input int bv_clamped);
        log_addr.delete();
        log_data.delete();
        done_cnt = 0; done_cyc = 0; last_wr_cyc = 0;
        acc = 0; ywr = 0; max_occ = 0;
        ready_seen = 0; stall_seen = 0;
        tb_bv = bv_clamped;
    endtask

    task automatic set_exp();
        for (int i = 0; i < N_SAMPLES; i++) exp_data[i] = '0;
        foreach (pairs[i]) begin
            exp_data[2*i]   = pairs[i].x;
            exp_data[2*i+1] = pairs[i].y;
        end
    endtask

    task automatic do_start(input logic [8:0] b);
        big_values = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int n);
        int  idx = 0;
        int  guard = 0;
        logic hs;
        pair_valid = 1'b1;
        x_val = pairs[0].x;
        y_val = pairs[0].y;
        while (idx < n && guard < 2000) begin
            @(negedge clk);
            hs = pair_ready;
            tick();
            guard++;
            if (hs) begin
                idx++;
                if (idx < n) begin
                    x_val = pairs[idx].x;
                    y_val = pairs[idx].y;
                end
            end
        end
        pair_valid = 1'b0;
        check("feed_timeout", 32'(guard < 2000), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (done_cnt == 0 && g < 2000) begin
            tick();
            g++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (5) tick();
    endtask

    task automatic check_granule(input string tag);
        int bad_a = 0;
        int bad_d = 0;
        check({tag, "_writes"}, log_addr.size(), N_SAMPLES);
        foreach (log_addr[i]) begin
            if (int'(log_addr[i]) != i) bad_a++;
            if (i < N_SAMPLES && log_data[i] !== exp_data[i]) bad_d++;
        end
        check({tag, "_addr_seq_bad"}, bad_a, 0);
        check({tag, "_data_bad"}, bad_d, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_lat"}, done_cyc - last_wr_cyc, 1);
    endtask

    initial begin
        pair_t p;

        // Reset state
        repeat (3) tick();
        check("rst_we", 32'(sample_we), 0);
        check("rst_addr", 32'(sample_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err_extra), 0);
        check("rst_ready", 32'(pair_ready), 0);
        rst = 1'b0;
        tick();

        // Basic order: bv=2, (3,-5) then (-1,0)
        pairs.delete();
        p.x = 16'sd3;  p.y = -16'sd5; pairs.push_back(p);
        p.x = -16'sd1; p.y = 16'sd0;  pairs.push_back(p);
        set_exp();
        clear_log(2);
        do_start(9'd2);
        check("basic_busy", 32'(busy), 1);
        feed(2);
        wait_done("basic");
        check_granule("basic");
        check("basic_addr1", 32'(log_data[1]), 32'h0000FFFB);
        check("basic_addr2", 32'(log_data[2]), 32'h0000FFFF);
        check("basic_busy_end", 32'(busy), 0);

        // Empty granule
        pairs.delete();
        set_exp();
        clear_log(0);
        do_start(9'd0);
        wait_done("empty");
        check_granule("empty");
        check("empty_ready_seen", 32'(ready_seen), 0);

        // Full granule, clamped from 400, valid held high
        pairs.delete();
        for (int i = 0; i < MAX_BIG_VALUES; i++) begin
            p.x = 16'(i + 1);
            p.y = 16'(-(i + 1));
            pairs.push_back(p);
        end
        set_exp();
        clear_log(MAX_BIG_VALUES);
        do_start(9'd400);
        feed(MAX_BIG_VALUES);
        wait_done("full");
        check_granule("full");
        check("full_last_addr", 32'(log_addr[log_addr.size()-1]), 575);
        check("full_last_data", 32'(log_data[log_data.size()-1]), 32'h0000FEE0);
        check("full_max_occ_le4", 32'(max_occ <= 4), 1);
        check("full_stall_seen", 32'(stall_seen), 1);

        // Overrun: bv=1, a second pair is offered
        pairs.delete();
        p.x = 16'sd7; p.y = -16'sd8; pairs.push_back(p);
        set_exp();
        clear_log(1);
        do_start(9'd1);
        feed(1);
        pair_valid = 1'b1;
        x_val = 16'sd99;
        y_val = 16'sd99;
        repeat (4) tick();
        pair_valid = 1'b0;
        check("ovr_err_set", 32'(err_extra), 1);
        wait_done("ovr");
        check_granule("ovr");
        check("ovr_err_sticky", 32'(err_extra), 1);
        pairs.delete();
        set_exp();
        clear_log(0);
        do_start(9'd0);
        check("ovr_err_cleared", 32'(err_extra), 0);
        wait_done("ovr_next");

        // Reset mid-granule around wr_idx=6
        pairs.delete();
        for (int i = 0; i < 5; i++) begin
            p.x = 16'(10 + i);
            p.y = 16'(20 + i);
            pairs.push_back(p);
        end
        clear_log(10);
        do_start(9'd10);
        feed(5);
        begin
            int g = 0;
            while (log_addr.size() < 6 && g < 200) begin
                tick();
                g++;
            end
            check("midrst_reached", 32'(log_addr.size() >= 6), 1);
        end
        #2 rst = 1'b1;
        #1;
        check("midrst_we", 32'(sample_we), 0);
        check("midrst_addr", 32'(sample_addr), 0);
        check("midrst_data", 32'(sample_data), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(pair_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("midrst_no_done", done_cnt, 0);
        pairs.delete();
        p.x = 16'sd5; p.y = 16'sd6; pairs.push_back(p);
        set_exp();
        clear_log(1);
        do_start(9'd1);
        feed(1);
        wait_done("postrst");
        check_granule("postrst");

        // start while busy in ZERO_FILL is ignored
        pairs.delete();
        set_exp();
        clear_log(0);
        do_start(9'd0);
        repeat (20) tick();
        do_start(9'd3);
        check("busy_start_busy", 32'(busy), 1);
        wait_done("busy_start");
        check_granule("busy_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
